// File: rtl/vec_outer_mul.sv
// Sequential LANES x LANES outer-product multiplier sharing one W x W multiplier.
// Optional saturation and sat_flag output enabled by VEC_OUTER_MUL_SAT_EN.

module vec_outer_mul_elem #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic         copy,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    logic [W-1:0] acc;

    // The last element is written on the same edge the result is published, so bypass it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            q   <= '0;
        end else begin
            if (wr)   acc <= din;
            if (copy) q   <= wr ? din : acc;
        end
    end
endmodule

module vec_outer_mul #(
    parameter int LANES = 2,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*W-1:0]       a,
    input  logic [LANES*W-1:0]       b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [LANES*LANES*W-1:0] y
`ifdef VEC_OUTER_MUL_SAT_EN
    ,
    output logic                     sat_flag
`endif
);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state;
    logic [LANES-1:0][W-1:0]   opa, opb;
    logic [IW-1:0]             i_idx, j_idx;
    logic [W-1:0]              wdata;
    logic                      calc, last;

    assign calc = (state == CALC);
    assign last = calc && (i_idx == LAST) && (j_idx == LAST);

`ifdef VEC_OUTER_MUL_SAT_EN
    logic [2*W-1:0] prod;
    logic           sat, sat_acc;
    assign prod  = opa[i_idx] * opb[j_idx];
    assign sat   = |prod[2*W-1:W];
    assign wdata = sat ? {W{1'b1}} : prod[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_acc  <= 1'b0;
            sat_flag <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sat_acc  <= 1'b0;
        end else if (calc) begin
            sat_acc  <= sat_acc | sat;
            if (last) sat_flag <= sat_acc | sat;
        end
    end
`else
    assign wdata = opa[i_idx] * opb[j_idx];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opa      <= a;
                    opb      <= b;
                    i_idx    <= '0;
                    j_idx    <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= CALC;
                end
                CALC: begin
                    if (j_idx == LAST) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                    if (last) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_i
        for (genvar gj = 0; gj < LANES; gj++) begin : g_j
            vec_outer_mul_elem #(.W(W)) u_elem (
                .clk  (clk),
                .rst  (rst),
                .wr   (calc && (i_idx == IW'(gi)) && (j_idx == IW'(gj))),
                .copy (last),
                .din  (wdata),
                .q    (y[(gi*LANES+gj)*W +: W])
            );
        end
    end
endmodule

// File: tb/tb_vec_outer_mul.sv
// Directed plus randomized checks of vec_outer_mul against an arithmetic reference model.

module tb_vec_outer_mul;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut0: LANES=2, W=16
    logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
    logic [31:0] a0, b0;
    logic [63:0] y0;
    // dut1: LANES=3, W=8
    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [23:0] a1, b1;
    logic [71:0] y1;
`ifdef VEC_OUTER_MUL_SAT_EN
    logic sat0, sat1;
`endif

    vec_outer_mul #(.LANES(2), .W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
        .busy(busy0), .y(y0)
`ifdef VEC_OUTER_MUL_SAT_EN
        , .sat_flag(sat0)
`endif
    );

    vec_outer_mul #(.LANES(3), .W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1), .y(y1)
`ifdef VEC_OUTER_MUL_SAT_EN
        , .sat_flag(sat1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every pairwise product, reduced to w bits by wrap or saturation.
    function automatic logic [127:0] ref_y(input int lanes, input int w,
                                           input logic [127:0] av, input logic [127:0] bv,
                                           output bit s);
        logic [127:0] r;
        longint unsigned m, x, z, p;
        r = '0;
        s = 1'b0;
        m = (64'd1 << w) - 1;
        for (int i = 0; i < lanes; i++) begin
            for (int j = 0; j < lanes; j++) begin
                x = 64'((av >> (i*w)) & 128'(m));
                z = 64'((bv >> (j*w)) & 128'(m));
                p = x * z;
                if (p > m) s = 1'b1;
`ifdef VEC_OUTER_MUL_SAT_EN
                if (p > m) p = m;
`else
                p = p & m;
`endif
                r = r | (128'(p) << ((i*lanes + j)*w));
            end
        end
        return r;
    endfunction

    function automatic logic ov(input int d); return d ? out_valid1 : out_valid0; endfunction
    function automatic logic ir(input int d); return d ? in_ready1 : in_ready0; endfunction
    function automatic logic [127:0] yo(input int d); return d ? 128'(y1) : 128'(y0); endfunction

    // Present operands, wait for accept, return cycles from accept edge to out_valid.
    task automatic op(input int d, input logic [127:0] av, input logic [127:0] bv, output int lat);
        int n;
        @(negedge clk);
        if (d == 0) begin a0 = av[31:0]; b0 = bv[31:0]; in_valid0 = 1'b1; end
        else        begin a1 = av[23:0]; b1 = bv[23:0]; in_valid1 = 1'b1; end
        n = 0;
        while (!ir(d) && n < 100) begin @(negedge clk); n++; end
        chk("accept_ready", 128'(ir(d)), 128'(1));
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        lat = 0;
        while (!ov(d) && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit s;
        logic [127:0] av, bv, ex, ysave;

        rst = 1'b1;
        in_valid0 = 0; out_ready0 = 1; a0 = '0; b0 = '0;
        in_valid1 = 0; out_ready1 = 1; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_y", yo(0), 128'(0));
        chk("rst_out_valid", 128'(out_valid0), 128'(0));
        chk("rst_in_ready", 128'(in_ready0), 128'(1));
        chk("rst_busy", 128'(busy0), 128'(0));

        // basic outer product
        av = 128'({16'd5, 16'd3}); bv = 128'({16'd11, 16'd7});
        op(0, av, bv, lat);
        chk("basic_latency", 128'(lat), 128'(4));
        chk("basic_y", yo(0), 128'({16'd55, 16'd35, 16'd33, 16'd21}));
        chk("basic_busy", 128'(busy0), 128'(1));
        ysave = yo(0);
        @(posedge clk); #1;
        chk("basic_in_ready_back", 128'(in_ready0), 128'(1));
        chk("basic_out_valid_drop", 128'(out_valid0), 128'(0));
        chk("basic_y_hold", yo(0), ysave);

        // wrap versus saturation
        av = 128'({16'd1, 16'h0100}); bv = 128'({16'd1, 16'h0100});
        op(0, av, bv, lat);
`ifdef VEC_OUTER_MUL_SAT_EN
        chk("sat_y", yo(0), 128'({16'd1, 16'h0100, 16'h0100, 16'hFFFF}));
        chk("sat_flag", 128'(sat0), 128'(1));
`else
        chk("wrap_y", yo(0), 128'({16'd1, 16'h0100, 16'h0100, 16'h0000}));
`endif
        @(posedge clk); #1;

        // randomized against the model
        for (int t = 0; t < 16; t++) begin
            av = 128'($urandom);
            bv = (t < 8) ? 128'($urandom & 32'h00FF_00FF) : 128'($urandom);
            op(0, av, bv, lat);
            ex = ref_y(2, 16, av, bv, s);
            chk("rand_latency", 128'(lat), 128'(4));
            chk("rand_y", yo(0), ex);
`ifdef VEC_OUTER_MUL_SAT_EN
            chk("rand_sat_flag", 128'(sat0), 128'(s));
`endif
            @(posedge clk); #1;
            chk("rand_in_ready", 128'(in_ready0), 128'(1));
        end

        // backpressure: stall in DONE, ignore in_valid pulse
        out_ready0 = 1'b0;
        av = 128'({16'd9, 16'd4}); bv = 128'({16'd2, 16'd6});
        op(0, av, bv, lat);
        chk("bp_latency", 128'(lat), 128'(4));
        ex = ref_y(2, 16, av, bv, s);
        chk("bp_y", yo(0), ex);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin a0 = 32'h0003_0003; b0 = 32'h0003_0003; in_valid0 = 1'b1; end
            if (c == 5) in_valid0 = 1'b0;
            chk("bp_y_stable", yo(0), ex);
            chk("bp_in_ready_low", 128'(in_ready0), 128'(0));
            chk("bp_out_valid_high", 128'(out_valid0), 128'(1));
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 128'(out_valid0), 128'(0));
        chk("bp_release_in_ready", 128'(in_ready0), 128'(1));
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("bp_no_second_transfer", 128'(out_valid0 | busy0), 128'(0));
        end
        chk("bp_y_kept", yo(0), ex);

        // reset two cycles into CALC
        av = 128'({16'd7, 16'd7}); bv = 128'({16'd7, 16'd7});
        @(negedge clk); a0 = av[31:0]; b0 = bv[31:0]; in_valid0 = 1'b1;
        @(posedge clk); #1; in_valid0 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rstmid_no_valid_yet", 128'(out_valid0), 128'(0));
        end
        rst = 1'b1;
        #1;
        chk("rstmid_y", yo(0), 128'(0));
        chk("rstmid_out_valid", 128'(out_valid0), 128'(0));
        chk("rstmid_busy", 128'(busy0), 128'(0));
        chk("rstmid_in_ready", 128'(in_ready0), 128'(1));
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("rstmid_out_valid_stays_low", 128'(out_valid0), 128'(0));
        end
        op(0, 128'({16'd2, 16'd2}), 128'({16'd2, 16'd2}), lat);
        chk("rstmid_next_latency", 128'(lat), 128'(4));
        chk("rstmid_next_y", yo(0), 128'({16'd4, 16'd4, 16'd4, 16'd4}));
        @(posedge clk); #1;

        // LANES=3, W=8
        av = 128'({8'd3, 8'd2, 8'd1}); bv = 128'({8'd6, 8'd5, 8'd4});
        op(1, av, bv, lat);
        chk("l3_latency", 128'(lat), 128'(9));
        chk("l3_y", yo(1), 128'({8'd18, 8'd15, 8'd12, 8'd12, 8'd10, 8'd8, 8'd6, 8'd5, 8'd4}));
        @(posedge clk); #1;
        for (int t = 0; t < 4; t++) begin
            av = 128'($urandom & 32'h00FF_FFFF);
            bv = 128'($urandom & 32'h00FF_FFFF);
            op(1, av, bv, lat);
            ex = ref_y(3, 8, av, bv, s);
            chk("l3_rand_latency", 128'(lat), 128'(9));
            chk("l3_rand_y", yo(1), ex);
`ifdef VEC_OUTER_MUL_SAT_EN
            chk("l3_rand_sat_flag", 128'(sat1), 128'(s));
`endif
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
